// File: rtl/rf_alu_sequencer_if.sv
// rf_alu_sequencer_if
// Handshake bundle between the instruction source / result consumer and the
// sequencer.
//   in_valid/in_ready/in_instr/in_imm        : instruction request channel
//   out_valid/out_ready/out_result/out_zero/
//   out_err                                  : result response channel
// Modports:
//   master : instruction source and result consumer side
//   slave  : sequencer side
interface rf_alu_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_instr;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_err;

  modport master (
    output in_valid, in_instr, in_imm, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_instr, in_imm, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_err
  );
endinterface

// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer
// Multi-cycle controller for a register-file/ALU datapath. Accepts one
// instruction per request handshake, walks IDLE -> EXEC -> WB -> RESP
// (compare skips WB, reserved opcode goes straight to RESP) and returns a
// result record on the response handshake.
// Ports:
//   clk        : clock, rising edge
//   clr        : asynchronous active-high reset
//   sif        : request/response handshake bundle (slave modport)
//   ra, rb, rw : datapath register addresses (registered)
//   aluc       : datapath ALU control (registered, passed through)
//   we         : register-file write enable, high only in WB
//   mux3       : write-back select, 1 = ALU result, 0 = rd
//   rd         : external write data (latched immediate)
//   alu_out    : datapath ALU result
//   zero       : datapath zero flag
//   retired    : count of completed response handshakes (wraps)
// Build option:
//   RF_ALU_SEQ_R0_GUARD_EN : suppress the write enable when rw = 0
module rf_alu_sequencer (
  input  logic                      clk,
  input  logic                      clr,
  rf_alu_sequencer_if.slave         sif,
  output logic [4:0]                ra,
  output logic [4:0]                rb,
  output logic [4:0]                rw,
  output logic [2:0]                aluc,
  output logic                      we,
  output logic                      mux3,
  output logic [31:0]               rd,
  input  logic [31:0]               alu_out,
  input  logic                      zero,
  output logic [15:0]               retired
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic [1:0]  r_state;
  logic [1:0]  r_op;
  logic [4:0]  r_ra;
  logic [4:0]  r_rb;
  logic [4:0]  r_rw;
  logic [2:0]  r_aluc;
  logic        r_we;
  logic        r_mux3;
  logic [31:0] r_rd;
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic        r_out_zero;
  logic        r_out_err;
  logic [15:0] r_retired;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_wb_we;

  // Gated by clr: the async reset parks the state in IDLE, but no
  // instruction may be accepted while reset is still asserted.
  assign w_in_ready = (r_state == S_IDLE) && !clr;
  assign w_accept   = sif.in_valid && w_in_ready;

`ifdef RF_ALU_SEQ_R0_GUARD_EN
  assign w_wb_we = (r_rw != '0);
`else
  assign w_wb_we = 1'b1;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state      <= S_IDLE;
      r_op         <= OP_ALU;
      r_ra         <= '0;
      r_rb         <= '0;
      r_rw         <= '0;
      r_aluc       <= '0;
      r_we         <= 1'b0;
      r_mux3       <= 1'b0;
      r_rd         <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_zero   <= 1'b0;
      r_out_err    <= 1'b0;
      r_retired    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ra   <= sif.in_instr[4:0];
            r_rb   <= sif.in_instr[9:5];
            r_rw   <= sif.in_instr[14:10];
            r_aluc <= sif.in_instr[17:15];
            r_op   <= sif.in_instr[19:18];
            r_rd   <= sif.in_imm;
            if (sif.in_instr[19:18] == OP_RSV) begin
              r_out_valid  <= 1'b1;
              r_out_err    <= 1'b1;
              r_out_result <= '0;
              r_out_zero   <= 1'b0;
              r_state      <= S_RESP;
            end else begin
              r_out_err <= 1'b0;
              r_state   <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (r_op == OP_LDI) begin
            r_out_result <= r_rd;
            r_out_zero   <= 1'b0;
          end else begin
            r_out_result <= alu_out;
            r_out_zero   <= zero;
          end
          if (r_op == OP_CMP) begin
            r_out_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            // we/mux3 are registered, so they are set on the EXEC->WB edge
            // to be valid for exactly the WB cycle.
            r_we    <= w_wb_we;
            r_mux3  <= (r_op == OP_ALU);
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_we        <= 1'b0;
          r_mux3      <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (sif.out_ready) begin
            r_out_valid <= 1'b0;
            r_retired   <= r_retired + 16'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sif.in_ready   = w_in_ready;
  assign sif.out_valid  = r_out_valid;
  assign sif.out_result = r_out_result;
  assign sif.out_zero   = r_out_zero;
  assign sif.out_err    = r_out_err;
  assign ra             = r_ra;
  assign rb             = r_rb;
  assign rw             = r_rw;
  assign aluc           = r_aluc;
  assign we             = r_we;
  assign mux3           = r_mux3;
  assign rd             = r_rd;
  assign retired        = r_retired;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
module tb_rf_alu_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [4:0]  ra, rb, rw;
  logic [2:0]  aluc;
  logic        we, mux3;
  logic [31:0] rd, alu_out;
  logic        zero;
  logic [15:0] retired;

  always #5 clk = ~clk;

  rf_alu_sequencer_if sif ();

  rf_alu_sequencer dut (
    .clk     (clk),
    .clr     (clr),
    .sif     (sif),
    .ra      (ra),
    .rb      (rb),
    .rw      (rw),
    .aluc    (aluc),
    .we      (we),
    .mux3    (mux3),
    .rd      (rd),
    .alu_out (alu_out),
    .zero    (zero),
    .retired (retired)
  );

  // Datapath model: 32x32 register file plus ALU
  // (aluc 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A).
  logic [31:0] rf [0:31] = '{default: 32'h0};

  always_comb begin
    alu_out = rf[ra];
    case (aluc)
      3'd0: alu_out = rf[ra] + rf[rb];
      3'd1: alu_out = rf[ra] - rf[rb];
      3'd2: alu_out = rf[ra] & rf[rb];
      3'd3: alu_out = rf[ra] | rf[rb];
      3'd4: alu_out = rf[ra] ^ rf[rb];
      default: alu_out = rf[ra];
    endcase
    zero = (alu_out == 32'h0);
  end

  always @(posedge clk) if (we) rf[rw] <= mux3 ? alu_out : rd;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  ra, rb, rw;
    logic [2:0]  aluc;
    logic [31:0] imm;
    logic [31:0] res;
    logic        zf;
    logic        err;
    int unsigned lat;
    logic        wexp;
  } vec_t;

  vec_t        tbl [10];
  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned n_ret = 0;

  function automatic vec_t mk(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] w, input logic [2:0] c, input logic [31:0] imm,
                              input logic [31:0] res, input logic zf, input logic err,
                              input int unsigned lat, input logic wexp);
    vec_t v;
    v.op = op; v.ra = a; v.rb = b; v.rw = w; v.aluc = c; v.imm = imm;
    v.res = res; v.zf = zf; v.err = err; v.lat = lat; v.wexp = wexp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_instr(input vec_t v);
    int unsigned w;
    w = 0;
    while (sif.in_ready !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_issue", {31'h0, sif.in_ready}, 32'h1);
    sif.in_valid = 1'b1;
    sif.in_instr = {v.op, v.aluc, v.rw, v.rb, v.ra};
    sif.in_imm   = v.imm;
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
    sif.in_instr = '0;
    sif.in_imm   = '0;
  endtask

  task automatic handshake();
    sif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    sif.out_ready = 1'b0;
    n_ret++;
    chk("retired", {16'h0, retired}, n_ret);
    chk("out_valid_drop", {31'h0, sif.out_valid}, 32'h0);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int unsigned lat, we_n, we_cyc;
    logic        m3;
    logic [4:0]  wrw;
    logic [31:0] wrd;
    lat = 0; we_n = 0; we_cyc = 0; m3 = 1'b0; wrw = '0; wrd = '0;
    drive_instr(v);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (we) begin
        we_n++; we_cyc = c; m3 = mux3; wrw = rw; wrd = rd;
      end
      if (sif.out_valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, ".latency"}, lat, v.lat);
    chk({tag, ".out_result"}, sif.out_result, v.res);
    chk({tag, ".out_zero"}, {31'h0, sif.out_zero}, {31'h0, v.zf});
    chk({tag, ".out_err"}, {31'h0, sif.out_err}, {31'h0, v.err});
    chk({tag, ".we_count"}, we_n, {31'h0, v.wexp});
    chk({tag, ".in_ready_in_resp"}, {31'h0, sif.in_ready}, 32'h0);
    chk({tag, ".ra_held"}, {27'h0, ra}, {27'h0, v.ra});
    if (we_n != 0) begin
      chk({tag, ".we_cycle"}, we_cyc, 32'd2);
      chk({tag, ".mux3"}, {31'h0, m3}, {31'h0, (v.op == 2'b00)});
      chk({tag, ".wb_rw"}, {27'h0, wrw}, {27'h0, v.rw});
      chk({tag, ".wb_rd"}, wrd, v.imm);
    end
    handshake();
  endtask

  initial begin
    vec_t        v;
    logic        gexp;
    logic [31:0] prior;

`ifdef RF_ALU_SEQ_R0_GUARD_EN
    gexp = 1'b0;
`else
    gexp = 1'b1;
`endif
    //            op    ra  rb  rw  aluc  imm            res            zf err lat we
    tbl[0] = mk(2'd1, 5'd0, 5'd0, 5'd3, 3'd0, 32'h000000A5, 32'h000000A5, 0, 0, 3, 1);
    tbl[1] = mk(2'd1, 5'd0, 5'd0, 5'd1, 3'd0, 32'h00000007, 32'h00000007, 0, 0, 3, 1);
    tbl[2] = mk(2'd1, 5'd0, 5'd0, 5'd2, 3'd0, 32'h00000005, 32'h00000005, 0, 0, 3, 1);
    tbl[3] = mk(2'd0, 5'd1, 5'd2, 5'd4, 3'd0, 32'h00000055, 32'h0000000C, 0, 0, 3, 1);
    tbl[4] = mk(2'd0, 5'd4, 5'd0, 5'd5, 3'd0, 32'h00000000, 32'h0000000C, 0, 0, 3, 1);
    tbl[5] = mk(2'd2, 5'd1, 5'd1, 5'd0, 3'd1, 32'h00000000, 32'h00000000, 1, 0, 2, 0);
    tbl[6] = mk(2'd2, 5'd1, 5'd2, 5'd0, 3'd1, 32'h00000000, 32'h00000002, 0, 0, 2, 0);
    tbl[7] = mk(2'd0, 5'd1, 5'd2, 5'd6, 3'd2, 32'h00000000, 32'h00000005, 0, 0, 3, 1);
    tbl[8] = mk(2'd3, 5'd9, 5'd10, 5'd11, 3'd4, 32'h00001234, 32'h00000000, 0, 1, 1, 0);
    tbl[9] = mk(2'd1, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 3, gexp);

    sif.in_valid  = 1'b0;
    sif.in_instr  = '0;
    sif.in_imm    = '0;
    sif.out_ready = 1'b0;
    clr = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst.in_ready", {31'h0, sif.in_ready}, 32'h0);
    chk("rst.addr", {17'h0, ra, rb, rw}, 32'h0);
    chk("rst.ctl", {27'h0, aluc, we, mux3}, 32'h0);
    chk("rst.rd", rd, 32'h0);
    chk("rst.out_flags", {29'h0, sif.out_valid, sif.out_zero, sif.out_err}, 32'h0);
    chk("rst.out_result", sif.out_result, 32'h0);
    chk("rst.retired", {16'h0, retired}, 32'h0);

    clr = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", {31'h0, sif.in_ready}, 32'h1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    chk("r4_written", rf[4], 32'h0000000C);

    // Reserved opcode with a stalled consumer; a request offered while busy
    // must be ignored.
    v = mk(2'd3, 5'd7, 5'd8, 5'd9, 3'd3, 32'h0000BEEF, 32'h0, 0, 1, 1, 0);
    drive_instr(v);
    @(negedge clk);
    chk("stall.valid_c1", {31'h0, sif.out_valid}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        sif.in_valid = 1'b1;
        sif.in_instr = {2'b01, 3'd0, 5'd7, 5'd0, 5'd0};
        sif.in_imm   = 32'hDEADDEAD;
      end
      chk("stall.out_valid", {31'h0, sif.out_valid}, 32'h1);
      chk("stall.out_result", sif.out_result, 32'h0);
      chk("stall.out_err", {31'h0, sif.out_err}, 32'h1);
      chk("stall.in_ready", {31'h0, sif.in_ready}, 32'h0);
      chk("stall.we", {31'h0, we}, 32'h0);
      @(negedge clk);
    end
    sif.in_valid = 1'b0;
    sif.in_instr = '0;
    sif.in_imm   = '0;
    chk("stall.rd_not_relatched", rd, 32'h0000BEEF);
    chk("stall.rw_not_relatched", {27'h0, rw}, 32'd9);
    handshake();

    // Reset during the write-back of r6 = r1 ^ r2: the write must not land.
    prior = rf[6];
    chk("r6_prior", prior, 32'h00000005);
    v = mk(2'd0, 5'd1, 5'd2, 5'd6, 3'd4, 32'h0, 32'h2, 0, 0, 3, 1);
    drive_instr(v);
    @(negedge clk);
    @(negedge clk);
    chk("clr.we_in_wb", {31'h0, we}, 32'h1);
    clr = 1'b1;
    #1;
    chk("clr.we_drop", {31'h0, we}, 32'h0);
    chk("clr.retired", {16'h0, retired}, 32'h0);
    chk("clr.in_ready", {31'h0, sif.in_ready}, 32'h0);
    chk("clr.ra", {27'h0, ra}, 32'h0);
    n_ret = 0;
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    chk("clr.in_ready_after", {31'h0, sif.in_ready}, 32'h1);
    chk("clr.r6_kept", rf[6], 32'h00000005);
    @(negedge clk);

    v = mk(2'd1, 5'd0, 5'd0, 5'd3, 3'd0, 32'h00001234, 32'h00001234, 0, 0, 3, 1);
    run_vec(v, "post_clr");
    chk("post_clr.r3", rf[3], 32'h00001234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
